// File: rtl/sram_arb_pkg.sv
// Shared definitions for SRAM port arbitration: FSM state encoding,
// requester indices and SRAM bus widths.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_ARB_IDLE  = 2'd0,
        S_ARB_OWN   = 2'd1,
        S_ARB_DRAIN = 2'd2
    } arb_state_type;

    localparam int REQ_UART = 0;
    localparam int REQ_M1   = 1;
    localparam int REQ_M2   = 2;
    localparam int REQ_VGA  = 3;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: returns the first set request at or
// after i_ptr (wrapping), as both a one-hot vector and an index.
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        logic [IDX_W-1:0] w_sel;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sel = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_valid && i_req[w_sel]) begin
                o_valid        = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_idx          = w_sel;
            end
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Round-robin owner arbiter for the shared SRAM port with read-return tagging.
// Optional ownership timeout enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int READ_LATENCY   = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [NUM_REQ-1:0]             i_req,
    output logic [NUM_REQ-1:0]             o_grant,
    input  logic [NUM_REQ*SRAM_ADDR_W-1:0] i_req_address,
    input  logic [NUM_REQ*SRAM_DATA_W-1:0] i_req_write_data,
    input  logic [NUM_REQ-1:0]             i_req_we_n,
    output logic [SRAM_ADDR_W-1:0]         o_sram_address,
    output logic [SRAM_DATA_W-1:0]         o_sram_write_data,
    output logic                           o_sram_we_n,
    output logic [NUM_REQ-1:0]             o_read_valid,
    output logic [NUM_REQ-1:0]             o_timeout,
    output logic [1:0]                     o_state
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DRAIN_W = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] ST_IDLE  = S_ARB_IDLE;
    localparam logic [1:0] ST_OWN   = S_ARB_OWN;
    localparam logic [1:0] ST_DRAIN = S_ARB_DRAIN;

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [NUM_REQ-1:0] r_tag [READ_LATENCY];

    logic [NUM_REQ-1:0] w_req_elig;
    logic [NUM_REQ-1:0] w_pick_grant;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [NUM_REQ-1:0] w_push;
    logic               w_timeout_hit;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0]    r_own_cnt;
    logic [NUM_REQ-1:0] r_ban;
    logic [NUM_REQ-1:0] r_timeout;

    assign w_timeout_hit = (r_state == ST_OWN) && i_req[r_owner] &&
                           (r_own_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_req_elig    = i_req & ~r_ban;
    assign o_timeout     = r_timeout;

    // A timed-out master stays banned until it has dropped its request once.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_own_cnt <= '0;
            r_ban     <= '0;
            r_timeout <= '0;
        end else begin
            r_own_cnt <= (r_state == ST_OWN) ? r_own_cnt + TO_W'(1) : '0;
            r_ban     <= (r_ban & i_req) | (w_timeout_hit ? r_grant : '0);
            r_timeout <= r_timeout | (w_timeout_hit ? r_grant : '0);
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout_hit    = 1'b0;
    assign w_req_elig       = i_req;
    assign o_timeout        = '0;
`endif

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_priority_select (
        .i_req   (w_req_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_next_ptr = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_grant;
                        r_owner <= w_pick_idx;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!i_req[r_owner] || w_timeout_hit) begin
                        r_grant     <= '0;
                        r_drain_cnt <= DRAIN_W'(READ_LATENCY - 1);
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Only cycles where the owner is still requesting count as issued reads.
    assign w_push = r_grant & i_req & i_req_we_n;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= w_push;
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_comb begin
        o_sram_address    = '0;
        o_sram_write_data = '0;
        o_sram_we_n       = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                o_sram_address    = i_req_address[i*SRAM_ADDR_W +: SRAM_ADDR_W];
                o_sram_write_data = i_req_write_data[i*SRAM_DATA_W +: SRAM_DATA_W];
                o_sram_we_n       = i_req_we_n[i];
            end
        end
    end

    assign o_grant      = r_grant;
    assign o_read_valid = r_tag[READ_LATENCY-1];
    assign o_state      = r_state;

endmodule
